debounce_scan: RTL and testbench

//  Multi-channel button/switch conditioner for the board front-end. NCH raw inputs share one

---
 rtl/debounce_scan.sv | 170 +++++++++++++++++
 tb/tb_debounce_scan.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/debounce_scan.sv
// debounce_scan: NCH-channel switch debouncer sharing one sample prescaler and a one-channel-per-clock scan.
// Optional auto-repeat on db_rise is built when DEBOUNCE_SCAN_AUTOREPEAT_EN is defined.
module debounce_scan #(
  parameter int NCH      = 4,
  parameter int PRE_BITS = 16,
  parameter int STABLE   = 15,
  parameter int REP_DLY  = 400,
  parameter int REP_PER  = 80
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] sw,
  output logic [NCH-1:0] db_level,
  output logic [NCH-1:0] db_rise,
  output logic [NCH-1:0] db_fall,
  output logic           sample_tick
);

  localparam int CW = $clog2(STABLE + 1);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  // The scan must finish before the next tick, and repeat timing must be ordered.
  if ((NCH < 1) || (NCH >= (1 << PRE_BITS)) || (REP_PER < 1) || (REP_PER > REP_DLY)) begin : g_bad_params
    $error("debounce_scan: invalid parameter combination");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  logic [NCH-1:0]      sync1_q, sync1_d;
  logic [NCH-1:0]      sync2_q, sync2_d;
  logic [PRE_BITS-1:0] pre_q, pre_d;
  logic                sample_tick_q, sample_tick_d;
  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q [NCH];
  logic [CW-1:0]       cnt_d [NCH];
  logic [NCH-1:0]      db_level_q, db_level_d;
  logic [NCH-1:0]      db_rise_q, db_rise_d;
  logic [NCH-1:0]      db_fall_q, db_fall_d;

`ifdef DEBOUNCE_SCAN_AUTOREPEAT_EN
  localparam int RW = $clog2(REP_DLY + 1);
  logic [RW-1:0]       rep_q [NCH];
  logic [RW-1:0]       rep_d [NCH];
`endif

  // Synchronizer and prescaler; the tick flag is registered alongside the counter it decodes.
  always_comb begin
    sync1_d       = sw;
    sync2_d       = sync1_q;
    pre_d         = pre_q + PRE_BITS'(1);
    sample_tick_d = &pre_d;
  end

  // Scheduler: one channel per clock after each tick.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (sample_tick_q) begin
          state_d = SCAN;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
          idx_d   = idx_q;
        end
      end
      SCAN: begin
        if (idx_q == IW'(NCH - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          state_d = SCAN;
          idx_d   = idx_q + IW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Per-channel evaluation in its scan slot; all other channels hold.
  always_comb begin
    db_level_d = db_level_q;
    db_rise_d  = '0;
    db_fall_d  = '0;
    cnt_d      = cnt_q;
    for (int i = 0; i < NCH; i++) begin
      if ((state_q == SCAN) && (idx_q == IW'(i))) begin
        if (sync2_q[i] == db_level_q[i]) begin
          cnt_d[i] = '0;
        end else if ((cnt_q[i] + CW'(1)) < CW'(STABLE)) begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end else begin
          cnt_d[i]      = '0;
          db_level_d[i] = ~db_level_q[i];
          db_rise_d[i]  = ~db_level_q[i];
          db_fall_d[i]  = db_level_q[i];
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
`ifdef DEBOUNCE_SCAN_AUTOREPEAT_EN
    rep_d = rep_q;
    for (int i = 0; i < NCH; i++) begin
      if ((state_q == SCAN) && (idx_q == IW'(i))) begin
        // Low, rising flip (level still 0 here) and falling flip all restart the delay.
        if (!db_level_q[i] || db_fall_d[i]) begin
          rep_d[i] = '0;
        end else if ((rep_q[i] + RW'(1)) == RW'(REP_DLY)) begin
          rep_d[i]     = RW'(REP_DLY - REP_PER);
          db_rise_d[i] = 1'b1;
        end else begin
          rep_d[i] = rep_q[i] + RW'(1);
        end
      end else begin
        rep_d[i] = rep_q[i];
      end
    end
`endif
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      pre_q         <= '0;
      sample_tick_q <= 1'b0;
      state_q       <= IDLE;
      idx_q         <= '0;
      db_level_q    <= '0;
      db_rise_q     <= '0;
      db_fall_q     <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
`ifdef DEBOUNCE_SCAN_AUTOREPEAT_EN
        rep_q[i] <= '0;
`endif
      end
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      pre_q         <= pre_d;
      sample_tick_q <= sample_tick_d;
      state_q       <= state_d;
      idx_q         <= idx_d;
      db_level_q    <= db_level_d;
      db_rise_q     <= db_rise_d;
      db_fall_q     <= db_fall_d;
      cnt_q         <= cnt_d;
`ifdef DEBOUNCE_SCAN_AUTOREPEAT_EN
      rep_q         <= rep_d;
`endif
    end
  end

  assign db_level    = db_level_q;
  assign db_rise     = db_rise_q;
  assign db_fall     = db_fall_q;
  assign sample_tick = sample_tick_q;

endmodule

// File: tb/tb_debounce_scan.sv
// tb_debounce_scan: directed bench for debounce_scan (NCH=4, PRE_BITS=4, STABLE=3, REP_DLY=5, REP_PER=2).
// Repeat expectations follow DEBOUNCE_SCAN_AUTOREPEAT_EN as seen by this compile.
module tb_debounce_scan;

  logic       clk;
  logic       reset;
  logic [3:0] sw;
  logic [3:0] db_level;
  logic [3:0] db_rise;
  logic [3:0] db_fall;
  logic       sample_tick;

  int checks = 0;
  int errors = 0;

`ifdef DEBOUNCE_SCAN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  debounce_scan #(
    .NCH(4), .PRE_BITS(4), .STABLE(3), .REP_DLY(5), .REP_PER(2)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw),
    .db_level(db_level), .db_rise(db_rise), .db_fall(db_fall),
    .sample_tick(sample_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the next negedge at which sample_tick is high (bounded).
  task automatic wait_tick(output int waited);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sample_tick !== 1'b1) && (n < 40));
    waited = n;
    checks++;
    assert (sample_tick === 1'b1) else begin
      errors++;
      $error("FAIL tick_timeout observed=%0b expected=1", sample_tick);
    end
  endtask

  task automatic settle_then_set(input logic [3:0] val);
    int w;
    wait_tick(w);
    step(8);
    sw = val;
  endtask

  initial begin
    int w;
    int tick_n, last_t, gap_bad;
    logic [3:0] rise_or, fall_or;
    logic [3:0] exp_r;

    reset = 1'b1;
    sw    = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_level", db_level, 4'b0000);
    chk("rst_rise", db_rise, 4'b0000);
    chk("rst_fall", db_fall, 4'b0000);
    chk("rst_tick", sample_tick, 1'b0);
    reset = 1'b0;

    // 1: idle inputs, tick cadence
    tick_n = 0; last_t = -1; gap_bad = 0; rise_or = 4'b0000; fall_or = 4'b0000;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      rise_or |= db_rise;
      fall_or |= db_fall;
      if (sample_tick === 1'b1) begin
        if ((last_t >= 0) && (k - last_t != 16)) gap_bad++;
        if ((last_t < 0) && (k != 15)) gap_bad++;
        last_t = k;
        tick_n++;
      end
    end
    chk("t1_ticks", tick_n, 12);
    chk("t1_gap", gap_bad, 0);
    chk("t1_level", db_level, 4'b0000);
    chk("t1_rise_any", rise_or, 4'b0000);
    chk("t1_fall_any", fall_or, 4'b0000);

    // 2: single channel rise on the third tick
    settle_then_set(4'b0001);
    wait_tick(w); wait_tick(w); wait_tick(w);
    step(1);
    chk("t2_level_t1", db_level, 4'b0000);
    chk("t2_rise_t1", db_rise, 4'b0000);
    step(1);
    chk("t2_level_t2", db_level, 4'b0001);
    chk("t2_rise_t2", db_rise, 4'b0001);
    chk("t2_fall_t2", db_fall, 4'b0000);
    step(1);
    chk("t2_rise_t3", db_rise, 4'b0000);
    chk("t2_level_t3", db_level, 4'b0001);

    // 3: short run rejected, full run accepted
    settle_then_set(4'b0101);
    wait_tick(w); wait_tick(w);
    step(4);
    chk("t3_short_rise", db_rise, 4'b0000);
    chk("t3_short_level", db_level, 4'b0001);
    sw = 4'b0001;
    wait_tick(w);
    step(4);
    chk("t3_reject_rise", db_rise, 4'b0000);
    chk("t3_reject_level", db_level, 4'b0001);
    settle_then_set(4'b0101);
    wait_tick(w); wait_tick(w); wait_tick(w);
    step(4);
    chk("t3_accept_rise", db_rise, 4'b0100);
    chk("t3_accept_level", db_level, 4'b0101);
    step(1);
    chk("t3_pulse_len", db_rise, 4'b0000);

    // 4: bring all low, then staggered rises and falls
    settle_then_set(4'b0000);
    wait_tick(w); wait_tick(w); wait_tick(w);
    step(2);
    chk("t4_fall0", db_fall, 4'b0001);
    step(2);
    chk("t4_fall2", db_fall, 4'b0100);
    chk("t4_level_low", db_level, 4'b0000);
    settle_then_set(4'b1111);
    wait_tick(w); wait_tick(w); wait_tick(w);
    step(1);
    chk("t4_rise_pre", db_rise, 4'b0000);
    for (int c = 0; c < 4; c++) begin
      step(1);
      exp_r = 4'b0001 << c;
      chk("t4_rise_stagger", db_rise, exp_r);
    end
    chk("t4_level_all", db_level, 4'b1111);
    step(1);
    chk("t4_rise_post", db_rise, 4'b0000);
    settle_then_set(4'b0000);
    wait_tick(w); wait_tick(w); wait_tick(w);
    step(1);
    for (int c = 0; c < 4; c++) begin
      step(1);
      exp_r = 4'b0001 << c;
      chk("t4_fall_stagger", db_fall, exp_r);
    end
    chk("t4_level_none", db_level, 4'b0000);

    // 5: reset in the middle of a scan with flips pending
    settle_then_set(4'b1111);
    wait_tick(w); wait_tick(w); wait_tick(w);
    step(2);
    chk("t5_pre_rise", db_rise, 4'b0001);
    reset = 1'b1;
    step(1);
    chk("t5_rst_level", db_level, 4'b0000);
    chk("t5_rst_rise", db_rise, 4'b0000);
    chk("t5_rst_fall", db_fall, 4'b0000);
    reset = 1'b0;
    wait_tick(w);
    chk("t5_first_tick", w, 15);
    wait_tick(w);
    step(5);
    chk("t5_no_early_flip", db_level, 4'b0000);
    wait_tick(w);
    step(2);
    chk("t5_resume_rise0", db_rise, 4'b0001);
    step(3);
    chk("t5_resume_rise3", db_rise, 4'b1000);
    chk("t5_resume_level", db_level, 4'b1111);

    // 6: channel 1 held high; repeats only with auto-repeat built in
    settle_then_set(4'b0000);
    wait_tick(w); wait_tick(w); wait_tick(w);
    step(5);
    chk("t6_level_low", db_level, 4'b0000);
    settle_then_set(4'b0010);
    wait_tick(w); wait_tick(w); wait_tick(w);
    step(3);
    chk("t6_flip_rise", db_rise, 4'b0010);
    for (int j = 1; j <= 8; j++) begin
      wait_tick(w);
      step(3);
      exp_r = (AR && ((j == 5) || (j == 7))) ? 4'b0010 : 4'b0000;
      chk("t6_repeat", db_rise, exp_r);
    end
    chk("t6_level_hold", db_level, 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
